// File: rtl/program_counter.sv
// WIDTH-bit program counter: clear / load / increment / hold, with a registered wrap pulse.
// Define PC_STICKY_OVF_EN to add a sticky overflow output ovf, cleared only by clr or reset.
module program_counter #(
  parameter int WIDTH     = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] d,
`ifdef PC_STICKY_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] q,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] q_q;
  logic             wrap_q;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] m_inc;
  logic [WIDTH-1:0] m_load;
  logic [WIDTH-1:0] q_d;
  logic             n_load;
  logic             n_clr;
  logic             wrap_c0;
  logic             wrap_c1;
  logic             wrap_d;

  assign carry[0] = 1'b1;

  // Half-adder ripple, then a per-bit mux chain whose order gives clr > load > inc > hold.
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_bit
    _xor u_sum    (.a(q_q[i]),    .b(carry[i]),   .y(sum[i]));
    _and u_cry    (.a(q_q[i]),    .b(carry[i]),   .y(carry[i+1]));
    _mux u_m_inc  (.a(q_q[i]),    .b(sum[i]),     .s(inc),  .y(m_inc[i]));
    _mux u_m_load (.a(m_inc[i]),  .b(d[i]),       .s(load), .y(m_load[i]));
    _mux u_m_clr  (.a(m_load[i]), .b(RST_VAL[i]), .s(clr),  .y(q_d[i]));
  end

  // A wrap only counts when the increment is the control that actually wins.
  _not u_n_load (.a(load), .y(n_load));
  _not u_n_clr  (.a(clr),  .y(n_clr));
  _and u_w0     (.a(carry[WIDTH]), .b(inc),    .y(wrap_c0));
  _and u_w1     (.a(wrap_c0),      .b(n_load), .y(wrap_c1));
  _and u_w2     (.a(wrap_c1),      .b(n_clr),  .y(wrap_d));

`ifdef PC_STICKY_OVF_EN
  logic ovf_q;
  logic ovf_set;
  logic ovf_d;

  _or  u_ovf_or  (.a(ovf_q),   .b(wrap_d), .y(ovf_set));
  _and u_ovf_and (.a(ovf_set), .b(n_clr),  .y(ovf_d));
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= RST_VAL;
      wrap_q <= 1'b0;
`ifdef PC_STICKY_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
`ifdef PC_STICKY_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// NAND-derived gate library; every gate below is composed from _nand.
module _nand (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module _not (
  input  logic a,
  output logic y
);
  _nand u_n (.a(a), .b(a), .y(y));
endmodule

module _and (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n;
  _nand u_n0 (.a(a), .b(b), .y(n));
  _nand u_n1 (.a(n), .b(n), .y(y));
endmodule

module _or (
  input  logic a,
  input  logic b,
  output logic y
);
  logic na;
  logic nb;
  _nand u_na (.a(a),  .b(a),  .y(na));
  _nand u_nb (.a(b),  .b(b),  .y(nb));
  _nand u_y  (.a(na), .b(nb), .y(y));
endmodule

module _xor (
  input  logic a,
  input  logic b,
  output logic y
);
  logic n0;
  logic n1;
  logic n2;
  _nand u_n0 (.a(a),  .b(b),  .y(n0));
  _nand u_n1 (.a(a),  .b(n0), .y(n1));
  _nand u_n2 (.a(b),  .b(n0), .y(n2));
  _nand u_y  (.a(n1), .b(n2), .y(y));
endmodule

// y = s ? b : a
module _mux (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  logic ns;
  logic pa;
  logic pb;
  _nand u_ns (.a(s),  .b(s),  .y(ns));
  _nand u_pa (.a(a),  .b(ns), .y(pa));
  _nand u_pb (.a(b),  .b(s),  .y(pb));
  _nand u_y  (.a(pa), .b(pb), .y(y));
endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: a 16-bit instance and a WIDTH=2, RESET_VAL=3 instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        load;
  logic        inc;
  logic [15:0] d;
  logic [15:0] q;
  logic        wrap;

  logic        s_rst_n;
  logic        s_clr;
  logic        s_load;
  logic        s_inc;
  logic [1:0]  s_d;
  logic [1:0]  s_q;
  logic        s_wrap;

`ifdef PC_STICKY_OVF_EN
  logic        ovf;
  logic        s_ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  program_counter #(.WIDTH(16), .RESET_VAL(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .load  (load),
    .inc   (inc),
    .d     (d),
`ifdef PC_STICKY_OVF_EN
    .ovf   (ovf),
`endif
    .q     (q),
    .wrap  (wrap)
  );

  program_counter #(.WIDTH(2), .RESET_VAL(3)) u_small (
    .clk   (clk),
    .rst_n (s_rst_n),
    .clr   (s_clr),
    .load  (s_load),
    .inc   (s_inc),
    .d     (s_d),
`ifdef PC_STICKY_OVF_EN
    .ovf   (s_ovf),
`endif
    .q     (s_q),
    .wrap  (s_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic c, input logic l, input logic i, input logic [15:0] dv);
    clr  = c;
    load = l;
    inc  = i;
    d    = dv;
  endtask

  logic [1:0] small_q_exp[8]    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic       small_wrap_exp[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    rst_n   = 1'b0;
    s_rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    s_clr  = 1'b0;
    s_load = 1'b0;
    s_inc  = 1'b0;
    s_d    = 2'd0;

    // Reset state
    @(negedge clk);
    check("reset_q", 32'(q), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset from a non-zero count
    drive(1'b0, 1'b1, 1'b0, 16'h1234);
    step();
    check("load_1234", 32'(q), 32'h1234);
    drive(1'b0, 1'b0, 1'b0, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("inc_after_rst_%0d", k), 32'(q), 32'(k));
    end

    // Wrap all-ones to zero
    drive(1'b0, 1'b1, 1'b0, 16'hFFFE);
    step();
    check("load_fffe", 32'(q), 32'hFFFE);
    check("load_fffe_wrap", 32'(wrap), 32'h0);
    drive(1'b0, 1'b0, 1'b1, 16'h0000);
    step();
    check("inc_ffff", 32'(q), 32'hFFFF);
    check("inc_ffff_wrap", 32'(wrap), 32'h0);
    step();
    check("wrap_q", 32'(q), 32'h0);
    check("wrap_pulse", 32'(wrap), 32'h1);
`ifdef PC_STICKY_OVF_EN
    check("ovf_set", 32'(ovf), 32'h1);
`endif
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("post_wrap_q_%0d", k), 32'(q), 32'(k));
      check($sformatf("post_wrap_wrap_%0d", k), 32'(wrap), 32'h0);
`ifdef PC_STICKY_OVF_EN
      check($sformatf("ovf_held_%0d", k), 32'(ovf), 32'h1);
`endif
    end

    // Priority: clr over load over inc
    drive(1'b0, 1'b1, 1'b0, 16'h0010);
    step();
    check("load_0010", 32'(q), 32'h0010);
    drive(1'b1, 1'b1, 1'b1, 16'h00A0);
    step();
    check("prio_clr", 32'(q), 32'h0000);
    check("prio_clr_wrap", 32'(wrap), 32'h0);
`ifdef PC_STICKY_OVF_EN
    check("ovf_cleared", 32'(ovf), 32'h0);
`endif
    drive(1'b0, 1'b1, 1'b1, 16'h00A0);
    step();
    check("prio_load", 32'(q), 32'h00A0);

    // clr on a would-be wrap edge
    drive(1'b0, 1'b1, 1'b0, 16'hFFFF);
    step();
    check("load_ffff", 32'(q), 32'hFFFF);
    drive(1'b1, 1'b0, 1'b1, 16'h0000);
    step();
    check("clr_vs_wrap_q", 32'(q), 32'h0);
    check("clr_vs_wrap_wrap", 32'(wrap), 32'h0);
`ifdef PC_STICKY_OVF_EN
    check("clr_vs_wrap_ovf", 32'(ovf), 32'h0);
`endif

    // load with inc on an all-ones count: load wins, no wrap
    drive(1'b0, 1'b1, 1'b0, 16'hFFFF);
    step();
    drive(1'b0, 1'b1, 1'b1, 16'h0000);
    step();
    check("load_over_wrap_q", 32'(q), 32'h0);
    check("load_over_wrap_wrap", 32'(wrap), 32'h0);

    // Hold, then load of zero
    drive(1'b0, 1'b1, 1'b0, 16'h7FFF);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h1111);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("hold_q_%0d", k), 32'(q), 32'h7FFF);
      check($sformatf("hold_wrap_%0d", k), 32'(wrap), 32'h0);
    end
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    step();
    check("load_zero_q", 32'(q), 32'h0);
    check("load_zero_wrap", 32'(wrap), 32'h0);

    // Small width: back-to-back wraps with inc held
    check("small_reset_q", 32'(s_q), 32'h3);
    check("small_reset_wrap", 32'(s_wrap), 32'h0);
    s_inc   = 1'b1;
    s_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("small_q_%0d", k + 1), 32'(s_q), 32'(small_q_exp[k]));
      check($sformatf("small_wrap_%0d", k + 1), 32'(s_wrap), 32'(small_wrap_exp[k]));
    end
`ifdef PC_STICKY_OVF_EN
    check("small_ovf", 32'(s_ovf), 32'h1);
`endif
    s_inc = 1'b0;
    s_clr = 1'b1;
    step();
    check("small_clr_q", 32'(s_q), 32'h3);
    check("small_clr_wrap", 32'(s_wrap), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Sequential program counter. Directly downstream consumer of the team's NAND-derived gate library (_not, _and, _or, _xor, _mux).
- First clocked stage in the hdl ladder: it holds a WIDTH-bit address and, each cycle, loads, increments, clears or holds it.
- Next-state datapath is structural, built only from library gate instances. The state register is the only behavioural logic.
- Feeds instruction-fetch addressing in later stages.

Parameters:
- WIDTH, 16, counter/address width in bits; legal range 2..32.
- RESET_VAL, 0, value q takes on async reset and on synchronous clr; truncated to WIDTH bits.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear to RESET_VAL, highest priority
- load  input  1  synchronous load of d
- inc  input  1  synchronous increment by 1
- d  input  WIDTH  load data
- q  output  WIDTH  current count, registered
- wrap  output  1  registered one-cycle pulse: the last update wrapped all-ones to zero

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- rst_n low, at any time including mid-cycle:
  - q = RESET_VAL and wrap = 0 immediately, with no clock required.
  - Release is sampled at the next rising clk edge.
- Per rising edge with rst_n high, first match wins:
  - clr -> q = RESET_VAL, wrap = 0
  - else load -> q = d, wrap = 0
  - else inc -> q = q + 1 mod 2^WIDTH; wrap = 1 only if old q was all ones, else 0
  - else hold -> q unchanged, wrap = 0
- Simultaneous controls:
  - clr with load or inc: clr wins.
  - load with inc: load wins; d is not incremented.
- Latency: q reflects the controls one cycle after the edge that samples them. No combinational path from any input to q or wrap.
- wrap:
  - Never asserts on load or clr, even if d or RESET_VAL is 0.
  - Back-to-back wraps can only occur when WIDTH is small and inc is held. Each wrapping edge pulses independently.
- Incrementer:
  - Ripple chain of half adders (sum = _xor, carry = _and), LSB carry-in tied to 1.
  - Final carry-out is the wrap candidate.
- Next-state selection:
  - Chain of per-bit _mux instances, in order hold/inc -> load -> clr.
  - Select lines are inc, load and clr respectively, so priority falls out structurally.
- Register: WIDTH+1 flops in a single always block, async reset on negedge rst_n.
- X on any control input while rst_n is high is a bench error. Behaviour is undefined and not checked.

Optional Feature:
- Macro: PC_STICKY_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - ovf sets on any edge where wrap would set, and stays 1 until clr or rst_n low.
  - ovf reset value 0. clr in the same cycle as a would-be wrap leaves ovf = 0.
- Undefined:
  - Port ovf and its flop do not exist.
  - Everything else is identical.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle with q=0x1234 -> q=0x0000 and wrap=0 before the next clk edge. Release, then 3 edges with inc=1 -> q=0x0003.
- Wrap: load d=0xFFFE, then inc for 2 edges -> q=0xFFFF with wrap=0, then q=0x0000 with wrap=1 for exactly one cycle.
- Priority: q=0x0010, d=0x00A0, clr=load=inc=1 -> q=0x0000. Next edge load=inc=1 -> q=0x00A0, not 0x00A1.
- Hold: all controls 0 for 5 edges from q=0x7FFF -> q stays 0x7FFF, wrap stays 0. Load d=0x0000 -> wrap stays 0.
- Small width: WIDTH=2, RESET_VAL=3, inc held for 8 edges from reset -> q sequence 0,1,2,3,0,1,2,3; wrap pulses on the 1st and 5th edges.
- PC_STICKY_OVF_EN defined: wrap once -> ovf=1 held through 4 further inc edges. clr -> ovf=0. Without the macro the bench compiles with no ovf port.
